branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- EX-stage companion to the branch history table; resolves each branch against the 2-bit prediction carried down from IF.
- Produces the history-table update stream (index, taken) through a small buffered valid/ready port.
- On mispredict, generates a registered redirect PC and a multi-cycle front-end flush.
- Keeps saturating branch and mispredict performance counters.

Parameters:
- PC_WIDTH, 32, width of all PC and target values.
- IDX_WIDTH, 6, history-table index width; table size is 2**IDX_WIDTH.
- FIFO_DEPTH, 4, update-buffer entries; power of two, at least 2.
- FLUSH_CYCLES, 2, cycles flush stays high per mispredict; at least 1.
- CNT_WIDTH, 32, width of each statistics counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  conditional branch present in EX this cycle.
- ex_pc  in  PC_WIDTH  PC of the branch.
- ex_pred_taken  in  1  prediction made in IF (history-table state MSB).
- ex_taken  in  1  resolved outcome.
- ex_target  in  PC_WIDTH  resolved taken target.
- ex_stall  out  1  update buffer full; EX must hold the branch.
- upd_valid  out  1  update entry available.
- upd_ready  in  1  history table accepts the update.
- upd_idx  out  IDX_WIDTH  table index, equal to ex_pc[IDX_WIDTH+1:2].
- upd_taken  out  1  outcome to train with.
- redirect_valid  out  1  one-cycle pulse; fetch must load redirect_pc.
- redirect_pc  out  PC_WIDTH  corrected fetch address.
- flush  out  1  squash IF/ID stages.
- stat_branches  out  CNT_WIDTH  resolved branches accepted.
- stat_mispredicts  out  CNT_WIDTH  mispredicted branches accepted.

Behaviour:
- Reset (asynchronous): FIFO empty, upd_valid=0, ex_stall=0, redirect_valid=0, redirect_pc=0, flush=0, FSM=IDLE, both counters 0. Reset mid-flush or mid-drain discards everything immediately.
- Acceptance: a branch is accepted when ex_valid && !ex_stall && FSM==IDLE. When FSM==FLUSH, ex_valid is ignored entirely: no enqueue, no count, no redirect, because that instruction is being squashed.
- ex_stall: combinational, equal to (FIFO count == FIFO_DEPTH). It does not depend on ex_valid or on a same-cycle dequeue.
- Update FIFO:
  - Each accepted branch enqueues {ex_pc[IDX_WIDTH+1:2], ex_taken}.
  - upd_valid = !empty; head data drives upd_idx/upd_taken.
  - Dequeue occurs on upd_valid && upd_ready.
  - No bypass: an entry written into an empty FIFO appears on upd_* the next cycle.
  - Simultaneous enqueue and dequeue leaves the count unchanged.
  - Entries leave in strict order; pointers wrap modulo FIFO_DEPTH.
  - upd_* data is held stable while upd_valid && !upd_ready.
- Mispredict condition: accepted && (ex_pred_taken != ex_taken).
- On mispredict, registered, next edge:
  - redirect_valid=1 for exactly one cycle.
  - redirect_pc = ex_taken ? ex_target : ex_pc+4, modulo 2**PC_WIDTH.
  - FSM goes to FLUSH with flush=1.
- Correct predictions update the FIFO and counters only; no redirect, no flush.
- FSM:
  - IDLE -> FLUSH on mispredict. The flush counter loads FLUSH_CYCLES-1.
  - FLUSH: flush=1; counter decrements each cycle; returns to IDLE after exactly FLUSH_CYCLES cycles of flush=1.
  - The first cycle back in IDLE may accept a new branch.
  - The mispredicting branch itself is still enqueued and counted.
- Counters:
  - stat_branches += 1 per accepted branch.
  - stat_mispredicts += 1 per accepted mispredict.
  - Both saturate at all-ones and never wrap.
- Stall while mispredicting: if the FIFO is full, the branch is not accepted, so no redirect occurs until it is accepted.

Test Plan:
- Reset, then 4 correct branches (ex_pc=0x100,0x104,0x108,0x10C; pred=taken=1) with upd_ready=1 -> upd_idx=0x00,0x01,0x02,0x03 each one cycle after its enqueue, taken=1; stat_branches=4; stat_mispredicts=0; flush never 1.
- Mispredict: ex_pc=0x200, pred=0, taken=1, target=0x340 -> next cycle redirect_valid=1 and redirect_pc=0x340; flush=1 for 2 cycles; an ex_valid pulse during flush is not counted; stat_mispredicts=1.
- Not-taken mispredict: ex_pc=0xFFFFFFFC, pred=1, taken=0 -> redirect_pc=0x00000000 (wrap); upd_taken=0.
- Backpressure: upd_ready=0 while 4 branches are accepted -> ex_stall=1 and a 5th ex_valid is held, not counted. Then upd_ready=1 for one cycle -> one dequeue, ex_stall drops next cycle, and the 5th branch is accepted.
- Simultaneous enqueue and dequeue at count=2 for 10 cycles -> count stays 2, order preserved, no stall.
- Assert rst_n low during flush with 3 FIFO entries -> flush, upd_valid and counters all 0 immediately; after release the first branch behaves as after a fresh reset.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Resolves each EX-stage conditional branch against the 2-bit prediction carried from IF.
//   It buffers history-table updates in a small FIFO, generates a registered redirect and a
//   multi-cycle front-end flush on a mispredict, and keeps saturating performance counters.
//
// Ports
//   clk, rst_n             clock (rising edge) and asynchronous active-low reset
//   ex_valid/ex_pc/...     branch resolved in EX this cycle (prediction, outcome, target)
//   ex_stall               update buffer full; EX must hold the branch
//   upd_valid/upd_ready    valid/ready port toward the history table
//   upd_idx/upd_taken      history-table index and training outcome
//   redirect_valid/_pc     one-cycle fetch redirect after a mispredict
//   flush                  squash IF/ID while high
//   stat_branches/_mispredicts  saturating statistics counters
module branch_resolve_unit #(
    parameter int unsigned PC_WIDTH     = 32,
    parameter int unsigned IDX_WIDTH    = 6,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ex_valid,
    input  logic [PC_WIDTH-1:0]  ex_pc,
    input  logic                 ex_pred_taken,
    input  logic                 ex_taken,
    input  logic [PC_WIDTH-1:0]  ex_target,
    output logic                 ex_stall,
    output logic                 upd_valid,
    input  logic                 upd_ready,
    output logic [IDX_WIDTH-1:0] upd_idx,
    output logic                 upd_taken,
    output logic                 redirect_valid,
    output logic [PC_WIDTH-1:0]  redirect_pc,
    output logic                 flush,
    output logic [CNT_WIDTH-1:0] stat_branches,
    output logic [CNT_WIDTH-1:0] stat_mispredicts
);

    localparam int unsigned PTRW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNTW = PTRW + 1;
    localparam int unsigned FCW  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int unsigned ENTW = IDX_WIDTH + 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_FLUSH = 1'b1;

    // Registered state
    logic [0:0]           state_q, state_d;
    logic [FCW-1:0]       fcnt_q, fcnt_d;
    logic                 flush_q, flush_d;
    logic                 redir_valid_q, redir_valid_d;
    logic [PC_WIDTH-1:0]  redir_pc_q, redir_pc_d;
    logic [ENTW-1:0]      mem_q [FIFO_DEPTH];
    logic [PTRW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]      count_q, count_d;
    logic [CNT_WIDTH-1:0] stat_br_q, stat_br_d;
    logic [CNT_WIDTH-1:0] stat_mp_q, stat_mp_d;

    logic full_c, empty_c, accept_c, mispredict_c, deq_c;

    // Status decode from registered FIFO occupancy only
    assign full_c       = (count_q == CNTW'(FIFO_DEPTH));
    assign empty_c      = (count_q == '0);
    assign accept_c     = ex_valid && !full_c && (state_q == S_IDLE);
    assign mispredict_c = accept_c && (ex_pred_taken != ex_taken);
    assign deq_c        = !empty_c && upd_ready;

    // Mispredict FSM: redirect pulse and flush window
    always_comb begin
        state_d       = state_q;
        fcnt_d        = fcnt_q;
        flush_d       = flush_q;
        redir_valid_d = 1'b0;
        redir_pc_d    = redir_pc_q;
        case (state_q)
            S_IDLE: begin
                if (mispredict_c) begin
                    state_d       = S_FLUSH;
                    fcnt_d        = FCW'(FLUSH_CYCLES - 1);
                    flush_d       = 1'b1;
                    redir_valid_d = 1'b1;
                    redir_pc_d    = ex_taken ? ex_target : ex_pc + PC_WIDTH'(4);
                end
            end
            S_FLUSH: begin
                // Counter hitting zero marks the last flush cycle
                if (fcnt_q == '0) begin
                    state_d = S_IDLE;
                    flush_d = 1'b0;
                end else begin
                    fcnt_d = fcnt_q - FCW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                flush_d = 1'b0;
            end
        endcase
    end

    // FIFO pointers, occupancy and saturating counters
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (accept_c) begin
            wr_ptr_d = wr_ptr_q + PTRW'(1);
        end
        if (deq_c) begin
            rd_ptr_d = rd_ptr_q + PTRW'(1);
        end
        if (accept_c && !deq_c) begin
            count_d = count_q + CNTW'(1);
        end else if (!accept_c && deq_c) begin
            count_d = count_q - CNTW'(1);
        end
        if (accept_c && (stat_br_q != '1)) begin
            stat_br_d = stat_br_q + CNT_WIDTH'(1);
        end
        if (mispredict_c && (stat_mp_q != '1)) begin
            stat_mp_d = stat_mp_q + CNT_WIDTH'(1);
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            fcnt_q        <= '0;
            flush_q       <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            stat_br_q     <= '0;
            stat_mp_q     <= '0;
        end else begin
            state_q       <= state_d;
            fcnt_q        <= fcnt_d;
            flush_q       <= flush_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            stat_br_q     <= stat_br_d;
            stat_mp_q     <= stat_mp_d;
        end
    end

    // Update buffer storage: {index, taken}
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (accept_c) begin
            mem_q[wr_ptr_q] <= {ex_pc[IDX_WIDTH+1:2], ex_taken};
        end
    end

    assign ex_stall         = full_c;
    assign upd_valid        = !empty_c;
    assign upd_idx          = mem_q[rd_ptr_q][IDX_WIDTH:1];
    assign upd_taken        = mem_q[rd_ptr_q][0];
    assign redirect_valid   = redir_valid_q;
    assign redirect_pc      = redir_pc_q;
    assign flush            = flush_q;
    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus random traffic,
// all checked every cycle against a queue-based behavioural model.
module tb_branch_resolve_unit;

    localparam int unsigned PCW   = 32;
    localparam int unsigned IW    = 6;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned FC    = 2;
    localparam int unsigned CW    = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           ex_valid = 1'b0;
    logic [PCW-1:0] ex_pc = '0;
    logic           ex_pred_taken = 1'b0;
    logic           ex_taken = 1'b0;
    logic [PCW-1:0] ex_target = '0;
    logic           ex_stall;
    logic           upd_valid;
    logic           upd_ready = 1'b0;
    logic [IW-1:0]  upd_idx;
    logic           upd_taken;
    logic           redirect_valid;
    logic [PCW-1:0] redirect_pc;
    logic           flush;
    logic [CW-1:0]  stat_branches;
    logic [CW-1:0]  stat_mispredicts;

    int n_tests = 0;
    int n_fail  = 0;

    branch_resolve_unit #(
        .PC_WIDTH(PCW), .IDX_WIDTH(IW), .FIFO_DEPTH(DEPTH),
        .FLUSH_CYCLES(FC), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
        .ex_taken(ex_taken), .ex_target(ex_target), .ex_stall(ex_stall),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_idx(upd_idx),
        .upd_taken(upd_taken), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .flush(flush),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: queue of {idx,taken}, remaining flush cycles, counters
    logic [IW:0]    m_q[$];
    int             m_flush_left;
    logic           m_redir_valid;
    logic [PCW-1:0] m_redir_pc;
    logic [CW-1:0]  m_br, m_mp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_flush_left  = 0;
            m_redir_valid = 1'b0;
            m_redir_pc    = '0;
            m_br          = '0;
            m_mp          = '0;
        end else begin
            bit acc, mis, deq;
            acc = ex_valid && (m_q.size() < DEPTH) && (m_flush_left == 0);
            mis = acc && (ex_pred_taken != ex_taken);
            deq = (m_q.size() > 0) && upd_ready;
            if (deq) void'(m_q.pop_front());
            if (acc) m_q.push_back({ex_pc[IW+1:2], ex_taken});
            if (acc && m_br != {CW{1'b1}}) m_br = m_br + 1;
            if (mis && m_mp != {CW{1'b1}}) m_mp = m_mp + 1;
            if (m_flush_left > 0) m_flush_left = m_flush_left - 1;
            else if (mis) m_flush_left = FC;
            m_redir_valid = mis;
            if (mis) m_redir_pc = ex_taken ? ex_target : ex_pc + 32'd4;
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            logic [IW:0] head;
            chk("ex_stall", 64'(ex_stall), 64'(m_q.size() == DEPTH));
            chk("upd_valid", 64'(upd_valid), 64'(m_q.size() > 0));
            if (m_q.size() > 0) begin
                head = m_q[0];
                chk("upd_idx", 64'(upd_idx), 64'(head[IW:1]));
                chk("upd_taken", 64'(upd_taken), 64'(head[0]));
            end
            chk("redirect_valid", 64'(redirect_valid), 64'(m_redir_valid));
            chk("redirect_pc", 64'(redirect_pc), 64'(m_redir_pc));
            chk("flush", 64'(flush), 64'(m_flush_left > 0));
            chk("stat_branches", 64'(stat_branches), 64'(m_br));
            chk("stat_mispredicts", 64'(stat_mispredicts), 64'(m_mp));
        end
    end

    // Apply inputs for one cycle, returning at the next falling edge
    task automatic drive(input logic v, input logic [PCW-1:0] pc, input logic pred,
                         input logic tk, input logic [PCW-1:0] tgt, input logic rdy);
        ex_valid      = v;
        ex_pc         = pc;
        ex_pred_taken = pred;
        ex_taken      = tk;
        ex_target     = tgt;
        upd_ready     = rdy;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_upd_valid", 64'(upd_valid), 64'd0);
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_stall", 64'(ex_stall), 64'd0);

        // Four correctly predicted branches streaming through
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 1'b1, 1'b1, 32'h0, 1'b1);
            chk("stream_idx", 64'(upd_idx), 64'(i));
            chk("stream_taken", 64'(upd_taken), 64'd1);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("stream_br", 64'(stat_branches), 64'd4);
        chk("stream_mp", 64'(stat_mispredicts), 64'd0);

        // Taken mispredict, with a squashed branch during the flush
        drive(1'b1, 32'h200, 1'b0, 1'b1, 32'h340, 1'b1);
        chk("mp_redir_valid", 64'(redirect_valid), 64'd1);
        chk("mp_redir_pc", 64'(redirect_pc), 64'h340);
        chk("mp_flush1", 64'(flush), 64'd1);
        drive(1'b1, 32'h500, 1'b0, 1'b1, 32'h600, 1'b1);
        chk("mp_flush2", 64'(flush), 64'd1);
        chk("mp_pulse_gone", 64'(redirect_valid), 64'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("mp_flush_done", 64'(flush), 64'd0);
        chk("mp_br", 64'(stat_branches), 64'd5);
        chk("mp_mp", 64'(stat_mispredicts), 64'd1);

        // Not-taken mispredict at top of address space wraps to zero
        drive(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h1234, 1'b1);
        chk("wrap_redir_pc", 64'(redirect_pc), 64'h0);
        chk("wrap_upd_taken", 64'(upd_taken), 64'd0);
        chk("wrap_upd_idx", 64'(upd_idx), 64'h3F);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Backpressure: fill, hold the fifth, single dequeue frees a slot
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h800 + 32'(4 * i), 1'b0, 1'b0, 32'h0, 1'b0);
        chk("bp_stall", 64'(ex_stall), 64'd1);
        drive(1'b1, 32'h810, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("bp_held_br", 64'(stat_branches), 64'd10);
        drive(1'b1, 32'h810, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("bp_stall_drop", 64'(ex_stall), 64'd0);
        chk("bp_still_held", 64'(stat_branches), 64'd10);
        drive(1'b1, 32'h810, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("bp_fifth_acc", 64'(stat_branches), 64'd11);
        chk("bp_stall_again", 64'(ex_stall), 64'd1);
        repeat (6) drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Steady simultaneous enqueue/dequeue at occupancy two
        drive(1'b1, 32'hA00, 1'b1, 1'b1, 32'h0, 1'b0);
        drive(1'b1, 32'hA04, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'hA08 + 32'(4 * i), 1'b1, 1'b1, 32'h0, 1'b1);
            chk("sim_no_stall", 64'(ex_stall), 64'd0);
        end
        repeat (4) drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Reset in the middle of a flush with three buffered entries
        drive(1'b1, 32'hC00, 1'b1, 1'b1, 32'h0, 1'b0);
        drive(1'b1, 32'hC04, 1'b1, 1'b1, 32'h0, 1'b0);
        drive(1'b1, 32'hC08, 1'b0, 1'b1, 32'hD00, 1'b0);
        chk("pre_rst_flush", 64'(flush), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_flush", 64'(flush), 64'd0);
        chk("rst_mid_upd_valid", 64'(upd_valid), 64'd0);
        chk("rst_mid_br", 64'(stat_branches), 64'd0);
        chk("rst_mid_mp", 64'(stat_mispredicts), 64'd0);
        chk("rst_mid_redir", 64'(redirect_pc), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 32'h100, 1'b1, 1'b1, 32'h0, 1'b1);
        chk("post_rst_br", 64'(stat_branches), 64'd1);
        chk("post_rst_idx", 64'(upd_idx), 64'd0);
        chk("post_rst_valid", 64'(upd_valid), 64'd1);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
                  $urandom() & 32'hFFFF_FFFC,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom() & 32'hFFFF_FFFC,
                  ($urandom_range(0, 9) < 5) ? 1'b1 : 1'b0);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
